layer_param_store: RTL
======================

// Module: layer_param_store
// PURPOSE
// - Per-layer weight/threshold store, directly downstream of config_manager.
// - Captures that layer's weight_wr_data/threshold_wr_data beats into PARALLEL_NEURONS banks.
// - Serves the layer's neuron-parallel compute engine with a 2-cycle pipelined read of
//   PARALLEL_NEURONS x PARALLEL_INPUTS weight bits plus the matching thresholds.
// - One instance per layer; wr_en inputs are that layer's bit of the config_manager vectors.
// PARAMETERS
// - BUS_WIDTH         64   config write word width; must be a multiple of PARALLEL_INPUTS
// - PARALLEL_INPUTS   8    weight bits per neuron per read (one chunk)
// - PARALLEL_NEURONS  8    banks; neurons read per group
// - INPUTS            784  inputs (weight bits) per neuron
// - NEURONS           256  neurons in this layer
// - THRESH_WIDTH      16   threshold bits; taken from threshold_wr_data[THRESH_WIDTH-1:0]
// - Derived: WPN=ceil(INPUTS/BUS_WIDTH), CHUNKS=ceil(INPUTS/PARALLEL_INPUTS),
//   GROUPS=ceil(NEURONS/PARALLEL_NEURONS)
// PORTS
// - clk               in   1                       clock
// - rst               in   1                       synchronous active-high reset
// - cfg_clear         in   1                       restart load: zero counters, drop load_done, clear overflow
// - weight_wr_data    in   BUS_WIDTH               weight word from config_manager
// - weight_wr_en      in   1                       weight word strobe for this layer
// - threshold_wr_data in   BUS_WIDTH               threshold word from config_manager
// - threshold_wr_en   in   1                       threshold strobe for this layer
// - load_done         out  1                       all NEURONS*WPN weights and NEURONS thresholds written
// - load_overflow     out  1                       sticky: strobe received after its count completed
// - rd_en             in   1                       read request
// - rd_group          in   $clog2(GROUPS)          neuron group
// - rd_chunk          in   $clog2(CHUNKS)          input chunk
// - rd_valid          out  1                       read data valid
// - rd_lane_valid     out  PARALLEL_NEURONS        lane p valid iff group*PN+p < NEURONS
// - rd_weights        out  PARALLEL_NEURONS*PARALLEL_INPUTS  lane p at [p*PI +: PI]
// - rd_thresholds     out  PARALLEL_NEURONS*THRESH_WIDTH     lane p at [p*TW +: TW]
// BEHAVIOUR
// - Reset: all outputs 0; word/neuron/bank/threshold counters 0; RAM contents not reset.
// - Weight order: neuron-major, WPN words per neuron, word 0 = bits [BUS_WIDTH-1:0].
//   Word w of neuron n -> bank n%PN, row (n/PN)*WPN+w; stored as received, pad bits untouched.
// - Weight counters: word counter wraps at WPN, advancing neuron (bank+1, wraps at PN -> group+1).
// - Thresholds: neuron counter tn -> threshold bank tn%PN, row tn/PN, one per strobe.
// - Weight and threshold strobes are independent; both may fire in the same cycle.
// - Strobe beyond NEURONS*WPN (weights) / NEURONS (thresholds): write dropped, counter holds,
//   load_overflow set.
// - load_done registered: rises the cycle after the last required write; held until cfg_clear/rst.
// - cfg_clear with a strobe in the same cycle: clear wins, write dropped.
// - cfg_clear mid-load: partial data abandoned; next strobe writes neuron 0 word 0.
// - Read: cycle t rd_en&&load_done -> RAM read at row group*WPN + (chunk*PI)/BUS_WIDTH;
//   t+1 -> register, select bits [(chunk*PI)%BUS_WIDTH +: PI];
//   t+2 -> rd_valid=1 with data; fully pipelined, one read per cycle.
// - rd_en while !load_done: ignored, rd_valid stays 0.
// - Out-of-range rd_group/rd_chunk: undefined data, rd_valid still asserted.
// - Invalid lanes: rd_weights/rd_thresholds lanes forced to 0.
// - cfg_clear/rst flush the read pipeline: in-flight rd_valid dropped.
// STRUCTURE
// - Shared package bnn_pkg: clog2 helper, WPN/CHUNKS/GROUPS derivation functions, lane-slice helper.
// - Sub-module param_bank_ram: simple dual-port 1-write/1-read RAM, registered read, width/depth
//   parameters; instantiated PN times for weights (BUS_WIDTH wide) and PN times for thresholds.
// - Top holds write counters, overflow/done logic, read pipeline and chunk mux.
// TESTING (bench params: BUS_WIDTH=16 PI=8 PN=2 INPUTS=16 NEURONS=5 TW=8; WPN=1 GROUPS=3)
// - Load neuron n weight {8'hA0+n,8'hB0+n}, thresholds 8'h10+n, n=0..4
//   -> load_done 1 cycle after last strobe; overflow 0.
// - After load, read g=2 c=1 -> 2 cycles later rd_valid=1, lane_valid=2'b01,
//   lane0 wt 8'hA4, lane1 wt 8'h00, lane0 thr 8'h14.
// - Back-to-back reads (0,0),(1,0),(1,1) on consecutive cycles -> three consecutive valid beats:
//   {B1,B0}, {B3,B2}, {A3,A2}.
// - 6th weight strobe after full load -> load_overflow=1, re-read g=0 c=0 still {B1,B0}.
// - cfg_clear coincident with strobe -> write dropped; next strobe lands at neuron 0,
//   load_done and overflow 0.
// - rd_en before load_done, and rst during active read -> rd_valid never asserts;
//   all outputs 0 the cycle after rst.

Source files
------------

// File: rtl/bnn_pkg.sv
// Purpose: shared sizing helpers for the BNN layer blocks.
//   clog2_min1   - address/index width, never below 1 bit
//   ceil_div     - integer ceiling division
//   calc_wpn     - config words per neuron
//   calc_chunks  - PARALLEL_INPUTS-wide chunks per neuron
//   calc_groups  - PARALLEL_NEURONS-wide neuron groups per layer
//   lane_lo      - low bit of lane `lane` in a packed vector of `w`-bit lanes
package bnn_pkg;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int calc_wpn(input int inputs, input int bus_width);
    return ceil_div(inputs, bus_width);
  endfunction

  function automatic int calc_chunks(input int inputs, input int par_inputs);
    return ceil_div(inputs, par_inputs);
  endfunction

  function automatic int calc_groups(input int neurons, input int par_neurons);
    return ceil_div(neurons, par_neurons);
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/param_bank_ram.sv
// Purpose: simple dual-port RAM, one write port and one registered read port.
// Ports:
//   clk_i    clock
//   we_i     write enable, waddr_i/wdata_i
//   re_i     read enable; rdata_o updates the cycle after re_i, holds otherwise
//   raddr_i  read address
// Contents are not reset.
module param_bank_ram
  import bnn_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = clog2_min1(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_param_store.sv
// Purpose: per-layer weight/threshold store. Captures config_manager weight and
// threshold beats into PARALLEL_NEURONS banks and serves a 2-cycle pipelined
// read of one chunk of every neuron in a group plus the matching thresholds.
// Ports:
//   clk_i, rst_i (sync, active high), cfg_clear_i (restart the load)
//   weight_wr_data_i/_en_i, threshold_wr_data_i/_en_i : config write beats
//   load_done_o     : every weight word and threshold written
//   load_overflow_o : sticky, a strobe arrived after its count completed
//   rd_en_i, rd_group_i, rd_chunk_i : read request
//   rd_valid_o, rd_lane_valid_o, rd_weights_o, rd_thresholds_o : read result (t+2)
module layer_param_store
  import bnn_pkg::*;
#(
  parameter int BUS_WIDTH        = 64,
  parameter int PARALLEL_INPUTS  = 8,
  parameter int PARALLEL_NEURONS = 8,
  parameter int INPUTS           = 784,
  parameter int NEURONS          = 256,
  parameter int THRESH_WIDTH     = 16,
  localparam int PN     = PARALLEL_NEURONS,
  localparam int PI     = PARALLEL_INPUTS,
  localparam int TW     = THRESH_WIDTH,
  localparam int WPN    = calc_wpn(INPUTS, BUS_WIDTH),
  localparam int CHUNKS = calc_chunks(INPUTS, PARALLEL_INPUTS),
  localparam int GROUPS = calc_groups(NEURONS, PARALLEL_NEURONS),
  localparam int GW     = clog2_min1(GROUPS),
  localparam int CW     = clog2_min1(CHUNKS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_clear_i,
  input  logic [BUS_WIDTH-1:0] weight_wr_data_i,
  input  logic                 weight_wr_en_i,
  input  logic [BUS_WIDTH-1:0] threshold_wr_data_i,
  input  logic                 threshold_wr_en_i,
  output logic                 load_done_o,
  output logic                 load_overflow_o,
  input  logic                 rd_en_i,
  input  logic [GW-1:0]        rd_group_i,
  input  logic [CW-1:0]        rd_chunk_i,
  output logic                 rd_valid_o,
  output logic [PN-1:0]        rd_lane_valid_o,
  output logic [PN*PI-1:0]     rd_weights_o,
  output logic [PN*TW-1:0]     rd_thresholds_o
);

  localparam int CPW    = BUS_WIDTH / PI;   // chunks per config word
  localparam int WW     = clog2_min1(WPN);
  localparam int BKW    = clog2_min1(PN);
  localparam int SW     = clog2_min1(CPW);
  localparam int WDEPTH = GROUPS * WPN;
  localparam int WAW    = clog2_min1(WDEPTH);

  // ---------------- write side ----------------
  logic [WW-1:0]  wword_q, wword_d;
  logic [BKW-1:0] wbank_q, wbank_d, tbank_q, tbank_d;
  logic [GW-1:0]  wgroup_q, wgroup_d, tgroup_q, tgroup_d;
  logic           wfull_q, wfull_d, tfull_q, tfull_d;
  logic           done_q, done_d, ovf_q, ovf_d;
  logic           w_last, t_last, w_go, t_go;

  assign w_last = (wword_q == WW'(WPN - 1)) &&
                  (32'(wgroup_q) * PN + 32'(wbank_q) == NEURONS - 1);
  assign t_last = (32'(tgroup_q) * PN + 32'(tbank_q) == NEURONS - 1);
  assign w_go   = weight_wr_en_i && !wfull_q && !cfg_clear_i && !rst_i;
  assign t_go   = threshold_wr_en_i && !tfull_q && !cfg_clear_i && !rst_i;

  always_comb begin
    wword_d  = wword_q;
    wbank_d  = wbank_q;
    wgroup_d = wgroup_q;
    wfull_d  = wfull_q;
    tbank_d  = tbank_q;
    tgroup_d = tgroup_q;
    tfull_d  = tfull_q;
    ovf_d    = ovf_q;
    if (cfg_clear_i) begin
      wword_d  = '0;
      wbank_d  = '0;
      wgroup_d = '0;
      wfull_d  = 1'b0;
      tbank_d  = '0;
      tgroup_d = '0;
      tfull_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (weight_wr_en_i) begin
        if (wfull_q) begin
          ovf_d = 1'b1;
        end else if (w_last) begin
          wfull_d = 1'b1;            // counters hold on the final word
        end else if (wword_q == WW'(WPN - 1)) begin
          wword_d = '0;
          if (wbank_q == BKW'(PN - 1)) begin
            wbank_d  = '0;
            wgroup_d = wgroup_q + 1'b1;
          end else begin
            wbank_d = wbank_q + 1'b1;
          end
        end else begin
          wword_d = wword_q + 1'b1;
        end
      end
      if (threshold_wr_en_i) begin
        if (tfull_q) begin
          ovf_d = 1'b1;
        end else if (t_last) begin
          tfull_d = 1'b1;
        end else if (tbank_q == BKW'(PN - 1)) begin
          tbank_d  = '0;
          tgroup_d = tgroup_q + 1'b1;
        end else begin
          tbank_d = tbank_q + 1'b1;
        end
      end
    end
    done_d = wfull_d && tfull_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wword_q  <= '0;
      wbank_q  <= '0;
      wgroup_q <= '0;
      wfull_q  <= 1'b0;
      tbank_q  <= '0;
      tgroup_q <= '0;
      tfull_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wword_q  <= wword_d;
      wbank_q  <= wbank_d;
      wgroup_q <= wgroup_d;
      wfull_q  <= wfull_d;
      tbank_q  <= tbank_d;
      tgroup_q <= tgroup_d;
      tfull_q  <= tfull_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign load_done_o     = done_q;
  assign load_overflow_o = ovf_q;

  // ---------------- read pipeline ----------------
  logic           rd_fire;
  logic [WAW-1:0] waddr, raddr;
  logic           v1_q;
  logic [GW-1:0]  g1_q;
  logic [SW-1:0]  sel1_q;

  assign rd_fire = rd_en_i && done_q && !cfg_clear_i && !rst_i;
  assign waddr   = WAW'(32'(wgroup_q) * WPN + 32'(wword_q));
  assign raddr   = WAW'(32'(rd_group_i) * WPN + 32'(rd_chunk_i) / CPW);

  logic [BUS_WIDTH-1:0] w_rdata [PN];
  logic [TW-1:0]        t_rdata [PN];

  for (genvar p = 0; p < PN; p++) begin : g_bank
    param_bank_ram #(.WIDTH(BUS_WIDTH), .DEPTH(WDEPTH), .AW(WAW)) u_wram (
      .clk_i  (clk_i),
      .we_i   (w_go && (wbank_q == BKW'(p))),
      .waddr_i(waddr),
      .wdata_i(weight_wr_data_i),
      .re_i   (rd_fire),
      .raddr_i(raddr),
      .rdata_o(w_rdata[p])
    );
    param_bank_ram #(.WIDTH(TW), .DEPTH(GROUPS), .AW(GW)) u_tram (
      .clk_i  (clk_i),
      .we_i   (t_go && (tbank_q == BKW'(p))),
      .waddr_i(tgroup_q),
      .wdata_i(threshold_wr_data_i[TW-1:0]),
      .re_i   (rd_fire),
      .raddr_i(rd_group_i),
      .rdata_o(t_rdata[p])
    );
  end

  if (TW < BUS_WIDTH) begin : g_thr_pad
    logic unused_thr_pad;
    assign unused_thr_pad = ^threshold_wr_data_i[BUS_WIDTH-1:TW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      g1_q   <= '0;
      sel1_q <= '0;
    end else begin
      v1_q   <= rd_fire;
      g1_q   <= rd_group_i;
      sel1_q <= SW'(32'(rd_chunk_i) % CPW);
    end
  end

  logic [PN-1:0]    lane_d, lane_q;
  logic [PN*PI-1:0] wts_d, wts_q;
  logic [PN*TW-1:0] thr_d, thr_q;
  logic             valid_q;

  // Lanes past the last neuron of a partial group read back as zero.
  always_comb begin
    lane_d = '0;
    wts_d  = '0;
    thr_d  = '0;
    for (int p = 0; p < PN; p++) begin
      if (v1_q && (32'(g1_q) * PN + 32'(p) < NEURONS)) begin
        lane_d[p]                  = 1'b1;
        wts_d[lane_lo(p, PI) +: PI] = w_rdata[p][32'(sel1_q) * PI +: PI];
        thr_d[lane_lo(p, TW) +: TW] = t_rdata[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_clear_i) begin
      valid_q <= 1'b0;
      lane_q  <= '0;
      wts_q   <= '0;
      thr_q   <= '0;
    end else begin
      valid_q <= v1_q;
      lane_q  <= lane_d;
      wts_q   <= wts_d;
      thr_q   <= thr_d;
    end
  end

  assign rd_valid_o      = valid_q;
  assign rd_lane_valid_o = lane_q;
  assign rd_weights_o    = wts_q;
  assign rd_thresholds_o = thr_q;

endmodule
